// File: rtl/box_overlay.sv
// Purpose : draws bounding-box outlines from the labelling stage onto the RGB pixel stream
// Latency : fixed 2 cycles from pix_valid/pix_in to pix_valid_out/pix_out
// Backpressure: none; every input cycle (valid or idle) moves through the pipeline
//
// Ports:
//   clk, rst              pixel clock, asynchronous active-high reset
//   box_valid, box_in     box strobe and packed {x_min, x_max, y_min, y_max}
//   sof, pix_valid, pix_in start-of-frame (pixel (0,0)), pixel strobe, RGB888 pixel
//   pix_valid_out, pix_out delayed strobe and RGB888 pixel with outlines drawn
//   box_count, overflow   box count / overflow flag of the bank being displayed
module box_overlay #(
    parameter int          imwidth   = 640,
    parameter int          imheight  = 480,
    parameter int          x_bit     = $clog2(imwidth),
    parameter int          y_bit     = $clog2(imheight),
    parameter int          data_bit  = 2 * (x_bit + y_bit),
    parameter int          max_boxes = 16,
    parameter int          cnt_bit   = $clog2(max_boxes + 1),
    parameter logic [23:0] box_color = 24'hFF0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                box_valid,
    input  logic [data_bit-1:0] box_in,
    input  logic                sof,
    input  logic                pix_valid,
    input  logic [23:0]         pix_in,
    output logic                pix_valid_out,
    output logic [23:0]         pix_out,
    output logic [cnt_bit-1:0]  box_count,
    output logic                overflow
);

    localparam int                 idx_bit = (max_boxes > 1) ? $clog2(max_boxes) : 1;
    localparam logic [x_bit-1:0]   x_last  = x_bit'(imwidth - 1);
    localparam logic [y_bit-1:0]   y_last  = y_bit'(imheight - 1);
    localparam logic [cnt_bit-1:0] cnt_max = cnt_bit'(max_boxes);

    // ------------------------------------------------------------------
    // Box capture into the write bank
    // ------------------------------------------------------------------
    logic [x_bit-1:0]   in_xmin, in_xmax;
    logic [y_bit-1:0]   in_ymin, in_ymax;
    logic               box_ok, box_acc, box_ovf, swap;
    logic               wr_sel;
    logic [cnt_bit-1:0] wr_cnt, wr_cnt_nxt;
    logic               wr_ovf, wr_ovf_nxt;

    logic [data_bit-1:0] bank [2][max_boxes];

    assign {in_xmin, in_xmax, in_ymin, in_ymax} = box_in;

    assign box_ok     = box_valid && (in_xmin <= in_xmax) && (in_ymin <= in_ymax);
    assign box_acc    = box_ok && (wr_cnt < cnt_max);
    assign box_ovf    = box_ok && (wr_cnt >= cnt_max);
    assign swap       = sof && pix_valid;
    assign wr_cnt_nxt = wr_cnt + cnt_bit'(box_acc);
    assign wr_ovf_nxt = wr_ovf | box_ovf;

    // Storage is not reset: entries at or above the bank count are never looked at.
    // A box arriving in the swap cycle lands in the retiring bank (old wr_sel),
    // which becomes the display bank on the very next cycle.
    always_ff @(posedge clk) begin
        if (box_acc) begin
            bank[wr_sel][wr_cnt[idx_bit-1:0]] <= box_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel    <= 1'b0;
            wr_cnt    <= '0;
            wr_ovf    <= 1'b0;
            box_count <= '0;
            overflow  <= 1'b0;
        end else if (swap) begin
            wr_sel    <= ~wr_sel;
            box_count <= wr_cnt_nxt;
            overflow  <= wr_ovf_nxt;
            wr_cnt    <= '0;
            wr_ovf    <= 1'b0;
        end else begin
            wr_cnt    <= wr_cnt_nxt;
            wr_ovf    <= wr_ovf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pixel coordinate counters: (x_cnt, y_cnt) is the position of the
    // next valid pixel unless sof forces it to (0,0).
    // ------------------------------------------------------------------
    logic [x_bit-1:0] x_cnt, cur_x;
    logic [y_bit-1:0] y_cnt, cur_y;

    assign cur_x = swap ? '0 : x_cnt;
    assign cur_y = swap ? '0 : y_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_valid) begin
            if (cur_x == x_last) begin
                x_cnt <= '0;
                y_cnt <= (cur_y == y_last) ? '0 : cur_y + 1'b1;
            end else begin
                x_cnt <= cur_x + 1'b1;
                y_cnt <= cur_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: register pixel and its coordinates. The swap itself is
    // already reflected in wr_sel/box_count by the time stage 2 runs.
    // ------------------------------------------------------------------
    logic             s1_vld;
    logic [23:0]      s1_pix;
    logic [x_bit-1:0] s1_x;
    logic [y_bit-1:0] s1_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_pix <= '0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else begin
            s1_vld <= pix_valid;
            if (pix_valid) begin
                s1_pix <= pix_in;
                s1_x   <= cur_x;
                s1_y   <= cur_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: parallel outline test against every live display entry
    // ------------------------------------------------------------------
    logic             disp_sel;
    logic             hit;
    logic [x_bit-1:0] e_xmin, e_xmax;
    logic [y_bit-1:0] e_ymin, e_ymax;

    assign disp_sel = ~wr_sel;

    always_comb begin
        hit    = 1'b0;
        e_xmin = '0;
        e_xmax = '0;
        e_ymin = '0;
        e_ymax = '0;
        for (int i = 0; i < max_boxes; i++) begin
            {e_xmin, e_xmax, e_ymin, e_ymax} = bank[disp_sel][i];
            if (cnt_bit'(i) < box_count) begin
                if (((s1_x == e_xmin) || (s1_x == e_xmax)) &&
                    (s1_y >= e_ymin) && (s1_y <= e_ymax)) begin
                    hit = 1'b1;
                end
                if (((s1_y == e_ymin) || (s1_y == e_ymax)) &&
                    (s1_x >= e_xmin) && (s1_x <= e_xmax)) begin
                    hit = 1'b1;
                end
            end
        end
    end

    // pix_out holds across idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid_out <= 1'b0;
            pix_out       <= '0;
        end else begin
            pix_valid_out <= s1_vld;
            if (s1_vld) begin
                pix_out <= hit ? box_color : s1_pix;
            end
        end
    end

endmodule

// File: tb/tb_box_overlay.sv
// Purpose : randomized self-checking bench for box_overlay against a frame-level box-list model
// Latency : expects outputs 2 cycles after each input cycle
// Backpressure: none; the bench drives one input cycle per clock
module tb_box_overlay;

    localparam int W  = 32;
    localparam int H  = 12;
    localparam int XB = $clog2(W);
    localparam int YB = $clog2(H);
    localparam int DB = 2 * (XB + YB);
    localparam int MB = 16;
    localparam int CB = $clog2(MB + 1);
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          box_valid = 1'b0;
    logic [DB-1:0] box_in = '0;
    logic          sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic [23:0]   pix_in = '0;
    logic          pix_valid_out;
    logic [23:0]   pix_out;
    logic [CB-1:0] box_count;
    logic          overflow;

    always #5 clk = ~clk;

    box_overlay #(
        .imwidth(W), .imheight(H), .max_boxes(MB), .box_color(RED)
    ) dut (
        .clk(clk), .rst(rst),
        .box_valid(box_valid), .box_in(box_in),
        .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .pix_valid_out(pix_valid_out), .pix_out(pix_out),
        .box_count(box_count), .overflow(overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: boxes as lists per frame ----------------
    typedef struct { int xmin; int xmax; int ymin; int ymax; } box_t;
    typedef struct { bit vld; logic [23:0] pix; int x; int y; } rec_t;

    box_t        pend[$];
    box_t        disp[$];
    box_t        tx[$];
    bit          pend_ovf;
    int          exp_count;
    bit          exp_ovf;
    int          m_x, m_y;
    rec_t        pipe[$];
    logic [23:0] exp_hold;
    logic [23:0] obs [H][W];

    function automatic logic [DB-1:0] pack(input box_t b);
        logic [XB-1:0] a, c;
        logic [YB-1:0] d, e;
        a = XB'(b.xmin); c = XB'(b.xmax);
        d = YB'(b.ymin); e = YB'(b.ymax);
        return {a, c, d, e};
    endfunction

    function automatic bit drawn(input int x, input int y);
        foreach (disp[i]) begin
            if (((x == disp[i].xmin || x == disp[i].xmax) && y >= disp[i].ymin && y <= disp[i].ymax) ||
                ((y == disp[i].ymin || y == disp[i].ymax) && x >= disp[i].xmin && x <= disp[i].xmax))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        pend.delete(); disp.delete(); pipe.delete();
        pend_ovf = 0; exp_count = 0; exp_ovf = 0;
        m_x = 0; m_y = 0; exp_hold = '0;
    endtask

    task automatic cyc(input bit s, input bit pv, input logic [23:0] p, input bit bv, input box_t b);
        rec_t r;
        sof = s; pix_valid = pv; pix_in = p; box_valid = bv; box_in = pack(b);
        if (bv && b.xmin <= b.xmax && b.ymin <= b.ymax) begin
            if (pend.size() < MB) pend.push_back(b);
            else pend_ovf = 1;
        end
        if (s && pv) begin
            disp = pend; pend.delete();
            exp_count = disp.size(); exp_ovf = pend_ovf; pend_ovf = 0;
            m_x = 0; m_y = 0;
        end
        r.vld = pv; r.x = m_x; r.y = m_y;
        r.pix = drawn(m_x, m_y) ? RED : p;
        if (pv) begin
            m_x++;
            if (m_x == W) begin m_x = 0; m_y++; if (m_y == H) m_y = 0; end
        end
        pipe.push_back(r);
        @(posedge clk); #1;
        if (pipe.size() >= 2) begin
            r = pipe.pop_front();
            if (r.vld) begin
                exp_hold = r.pix;
                obs[r.y][r.x] = pix_out;
            end
            check("pix_valid_out", 32'(pix_valid_out), 32'(r.vld));
            check("pix_out", 32'(pix_out), 32'(exp_hold));
        end
        check("box_count", 32'(box_count), 32'(exp_count));
        check("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    // One frame starting with sof; pending tx boxes go out one per cycle.
    task automatic frame(input bit fixed, input logic [23:0] col, input bit box_on_sof, input int npix);
        box_t b, z;
        bit   bv;
        z = '{0, 0, 0, 0};
        for (int i = 0; i < npix; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                bv = 0; b = z;
                if (tx.size() > 0) begin b = tx.pop_front(); bv = 1; end
                cyc(1'($urandom_range(0, 1)), 1'b0, 24'($urandom), bv, b);
            end
            bv = 0; b = z;
            if (tx.size() > 0 && (i > 0 || box_on_sof)) begin b = tx.pop_front(); bv = 1; end
            cyc(i == 0, 1'b1, fixed ? col : 24'($urandom), bv, b);
        end
        cyc(1'b0, 1'b0, 24'h0, 1'b0, z);
    endtask

    function automatic box_t rand_box(input bit allow_degen);
        box_t b;
        b.xmin = $urandom_range(0, W - 1);
        b.ymin = $urandom_range(0, H - 1);
        b.xmax = allow_degen ? $urandom_range(0, W - 1) : $urandom_range(b.xmin, W - 1);
        b.ymax = allow_degen ? $urandom_range(0, H - 1) : $urandom_range(b.ymin, H - 1);
        return b;
    endfunction

    int   reds;
    box_t zb;

    initial begin
        zb = '{0, 0, 0, 0};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_valid_out", 32'(pix_valid_out), 0);
        check("rst_pix_out", 32'(pix_out), 0);
        check("rst_box_count", 32'(box_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;

        // no boxes: straight pass-through
        frame(0, 24'h0, 0, W * H);
        frame(0, 24'h0, 0, W * H);

        // one box, drawn on the following frame only
        tx.push_back('{10, 20, 5, 8});
        frame(0, 24'h0, 0, W * H);
        frame(1, GREEN, 0, W * H);
        check("box_10_5", 32'(obs[5][10]), 32'(RED));
        check("box_20_8", 32'(obs[8][20]), 32'(RED));
        check("box_15_5", 32'(obs[5][15]), 32'(RED));
        check("box_10_7", 32'(obs[7][10]), 32'(RED));
        check("box_15_6", 32'(obs[6][15]), 32'(GREEN));
        check("box_9_5", 32'(obs[5][9]), 32'(GREEN));
        check("box_21_8", 32'(obs[8][21]), 32'(GREEN));
        check("box_count_one", 32'(box_count), 1);
        frame(1, GREEN, 0, W * H);
        check("stale_10_5", 32'(obs[5][10]), 32'(GREEN));
        check("stale_count", 32'(box_count), 0);

        // box in the same cycle as sof belongs to the retiring frame
        tx.push_back('{1, 3, 1, 3});
        frame(1, GREEN, 1, W * H);
        check("sofbox_1_1", 32'(obs[1][1]), 32'(RED));
        check("sofbox_2_2", 32'(obs[2][2]), 32'(GREEN));
        check("sofbox_count", 32'(box_count), 1);

        // capacity overflow
        for (int k = 0; k < MB + 1; k++) tx.push_back(rand_box(0));
        frame(0, 24'h0, 0, W * H);
        frame(0, 24'h0, 0, W * H);
        check("ovf_count", 32'(box_count), MB);
        check("ovf_flag", 32'(overflow), 1);
        frame(0, 24'h0, 0, W * H);
        check("ovf_clear", 32'(overflow), 0);

        // degenerate box dropped, single-pixel box at the corner
        tx.push_back('{30, 20, 5, 8});
        tx.push_back('{0, 0, 0, 0});
        frame(0, 24'h0, 0, W * H);
        frame(1, GREEN, 0, W * H);
        reds = 0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                if (obs[yy][xx] == RED) reds++;
        check("single_0_0", 32'(obs[0][0]), 32'(RED));
        check("single_red_pixels", 32'(reds), 1);
        check("single_count", 32'(box_count), 1);

        // random boxes, including degenerate ones
        for (int f = 0; f < 4; f++) begin
            int nb;
            nb = $urandom_range(0, 20);
            for (int k = 0; k < nb; k++) tx.push_back(rand_box($urandom_range(0, 3) == 0));
            frame(0, 24'h0, 0, W * H);
        end
        frame(0, 24'h0, 0, W * H);

        // reset mid-frame with boxes pending and displayed
        for (int k = 0; k < 5; k++) tx.push_back(rand_box(0));
        frame(0, 24'h0, 0, W * H);
        for (int k = 0; k < 5; k++) tx.push_back(rand_box(0));
        frame(0, 24'h0, 0, W * H / 2);
        #2 rst = 1'b1;
        #1;
        check("midrst_pix_valid_out", 32'(pix_valid_out), 0);
        check("midrst_pix_out", 32'(pix_out), 0);
        check("midrst_box_count", 32'(box_count), 0);
        check("midrst_overflow", 32'(overflow), 0);
        model_reset();
        tx.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 24'($urandom), 1'b0, zb);
        frame(0, 24'h0, 0, W * H);
        check("postrst_count", 32'(box_count), 0);
        frame(0, 24'h0, 0, W * H);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
